// File: rtl/boxhead_fb_pkg.sv
// Shared definitions for the frame write buffer.
//   FB_ADDR_W  : SRAM word address width (1M words)
//   FB_DATA_W  : SRAM word width
//   FB_COORD_W : pixel-word column/row width
//   fb_entry_t : one queued write {x, y, data}
//   fb_state_t : drain FSM states
//   fb_addr()  : builds the SRAM address for an entry in a given frame half
package boxhead_fb_pkg;

  localparam int FB_ADDR_W  = 20;
  localparam int FB_DATA_W  = 16;
  localparam int FB_COORD_W = 10;

  typedef struct packed {
    logic [FB_COORD_W-1:0] x;
    logic [FB_COORD_W-1:0] y;
    logic [FB_DATA_W-1:0]  data;
  } fb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2
  } fb_state_t;

  // Address layout: {frame half, row[8:0], column[9:0]}. Rows are below 512,
  // so row bit 9 never reaches the address.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic half,
                                                   input fb_entry_t e);
    return {half, e.y[8:0], e.x};
  endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock FIFO used as the frame write queue.
//   clk, reset_n : clock, asynchronous active-low reset (resets to empty)
//   push, din    : write din when not full, or when a pop frees the slot
//   pop          : discard head when not empty
//   full, empty  : status from pointers carrying an extra wrap bit
//   head         : current head entry (valid while !empty)
//   level        : number of stored entries
// Storage is not reset; only the pointers define what is valid.
module fb_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign level = r_wr_ptr - r_rd_ptr;
  assign head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_pop  = pop && !empty;
  // On a full queue the popped slot is the one being written, so a same-cycle
  // push is safe: the head is consumed at the same edge it is overwritten.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/frame_write_buffer.sv
// Frame write buffer: queues pixel-word writes from the copy engine and drains
// them into the back half of the double-buffered SRAM frame store through a
// req/gnt arbiter port. Owns current_frame and flips it at vsync once the
// engine is done and the queue is empty.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   program_write/x/y/data : 1-cycle write strobe with coordinates and word
//   engine_done, vsync_pulse : flip request inputs
//   current_frame, flip_done : displayed frame, 1-cycle pulse on toggle
//   overflow            : sticky, a write was dropped on a full queue
//   sram_req/gnt/addr/wdata/we : SRAM arbiter port
//   dbg_state           : drain FSM state for observation
// Build option: FB_TRANSPARENT_SKIP_EN -- when defined, in-range words with
// data 16'h0000 are accepted but never queued or written.
//
// Handshake: sram_req is held from REQ through WRITE. sram_gnt is sampled only
// in REQ; once granted, the port is owned for the whole WE_CYCLES strobe and
// gnt is ignored until the FSM returns to REQ or IDLE.
module frame_write_buffer
  import boxhead_fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int WE_CYCLES  = 2,
  parameter int X_MAX      = 640,
  parameter int Y_MAX      = 480
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  program_write,
  input  logic [FB_COORD_W-1:0] program_x,
  input  logic [FB_COORD_W-1:0] program_y,
  input  logic [FB_DATA_W-1:0]  program_data,
  input  logic                  engine_done,
  input  logic                  vsync_pulse,
  output logic                  current_frame,
  output logic                  flip_done,
  output logic                  overflow,
  output logic                  sram_req,
  input  logic                  sram_gnt,
  output logic [FB_ADDR_W-1:0]  sram_addr,
  output logic [FB_DATA_W-1:0]  sram_wdata,
  output logic                  sram_we,
  output fb_state_t             dbg_state
);

  localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  fb_state_t            r_state;
  logic [CNT_W-1:0]     r_we_cnt;
  logic                 r_cf;
  logic                 r_flip_done;
  logic                 r_flip_pending;
  logic                 r_overflow;
  logic                 r_sram_req;
  logic                 r_sram_we;
  logic [FB_ADDR_W-1:0] r_sram_addr;
  logic [FB_DATA_W-1:0] r_sram_wdata;

  logic                 w_in_range;
  logic                 w_skip;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_ok;
  logic                 w_pop;
  logic                 w_last_we;
  logic                 w_more;
  logic                 w_overflow_set;
  logic [LW-1:0]        w_level;
  fb_entry_t            w_head;
  fb_entry_t            w_new;
  logic [$bits(fb_entry_t)-1:0] w_head_bits;

  assign w_in_range = (32'(program_x) < X_MAX) && (32'(program_y) < Y_MAX);

`ifdef FB_TRANSPARENT_SKIP_EN
  assign w_skip = (program_data == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_last_we = (r_state == WRITE) && (r_we_cnt == CNT_W'(WE_CYCLES - 1));
  assign w_pop     = w_last_we;

  // A pop in the same cycle frees a slot, so a full queue still takes the push.
  assign w_push_ok      = program_write && w_in_range && !w_skip && (!w_full || w_pop);
  assign w_overflow_set = program_write && w_in_range && !w_skip && w_full && !w_pop;

  // Queue still holds work after this cycle's pop.
  assign w_more = (w_level > LW'(1)) || w_push_ok;

  assign w_new  = '{x: program_x, y: program_y, data: program_data};
  assign w_head = fb_entry_t'(w_head_bits);

  fb_sync_fifo #(
    .WIDTH ($bits(fb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push_ok),
    .pop     (w_pop),
    .din     (w_new),
    .full    (w_full),
    .empty   (w_empty),
    .head    (w_head_bits),
    .level   (w_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_we_cnt       <= '0;
      r_cf           <= 1'b0;
      r_flip_done    <= 1'b0;
      r_flip_pending <= 1'b0;
      r_overflow     <= 1'b0;
      r_sram_req     <= 1'b0;
      r_sram_we      <= 1'b0;
      r_sram_addr    <= '0;
      r_sram_wdata   <= '0;
    end else begin
      r_flip_done <= 1'b0;
      if (w_overflow_set)             r_overflow     <= 1'b1;
      if (vsync_pulse && engine_done) r_flip_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          // A push arriving now beats a pending flip; the flip waits for the
          // queue to drain again.
          if (w_push_ok || !w_empty) begin
            r_state    <= REQ;
            r_sram_req <= 1'b1;
          end else if (r_flip_pending) begin
            r_cf           <= ~r_cf;
            r_flip_done    <= 1'b1;
            r_flip_pending <= 1'b0;
            r_overflow     <= 1'b0;
          end
        end
        REQ: begin
          if (sram_gnt) begin
            r_state      <= WRITE;
            r_sram_we    <= 1'b1;
            r_we_cnt     <= '0;
            r_sram_addr  <= fb_addr(~r_cf, w_head);
            r_sram_wdata <= w_head.data;
          end
        end
        WRITE: begin
          if (w_last_we) begin
            r_sram_we <= 1'b0;
            if (w_more) begin
              r_state <= REQ;
            end else begin
              r_state    <= IDLE;
              r_sram_req <= 1'b0;
            end
          end else begin
            r_we_cnt <= r_we_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_sram_req <= 1'b0;
          r_sram_we  <= 1'b0;
        end
      endcase
    end
  end

  assign current_frame = r_cf;
  assign flip_done     = r_flip_done;
  assign overflow      = r_overflow;
  assign sram_req      = r_sram_req;
  assign sram_we       = r_sram_we;
  assign sram_addr     = r_sram_addr;
  assign sram_wdata    = r_sram_wdata;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_frame_write_buffer.sv
// Directed bench for frame_write_buffer (default parameters).
module tb_frame_write_buffer;
  import boxhead_fb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        program_write;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;
  logic        engine_done;
  logic        vsync_pulse;
  logic        current_frame;
  logic        flip_done;
  logic        overflow;
  logic        sram_req;
  logic        sram_gnt;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we;
  fb_state_t   dbg_state;

  int total = 0;
  int bad   = 0;

  // scoreboard: {addr, data} per SRAM write, expected vs captured
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  logic        prev_we = 1'b0;

  frame_write_buffer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .program_write (program_write),
    .program_x     (program_x),
    .program_y     (program_y),
    .program_data  (program_data),
    .engine_done   (engine_done),
    .vsync_pulse   (vsync_pulse),
    .current_frame (current_frame),
    .flip_done     (flip_done),
    .overflow      (overflow),
    .sram_req      (sram_req),
    .sram_gnt      (sram_gnt),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_we       (sram_we),
    .dbg_state     (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // driver / sampling tasks
  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one cycle; sample 1 time unit after the edge, capture write starts
  task automatic tick();
    @(posedge clk);
    #1;
    if (sram_we && !prev_we) got_q.push_back({sram_addr, sram_wdata});
    prev_we = sram_we;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d);
    program_write = 1'b1;
    program_x     = x;
    program_y     = y;
    program_data  = d;
    tick();
    program_write = 1'b0;
  endtask

  task automatic compare_sb(input string tag);
    int n;
    check({tag, "_count"}, 36'(got_q.size()), 36'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int flip_seen;
    int writes_at_flip;
    logic cf_at_flip;
    logic ovf_at_flip;
    logic fd_after;

    reset_n = 1'b0;
    program_write = 1'b0;
    program_x = '0;
    program_y = '0;
    program_data = '0;
    engine_done = 1'b0;
    vsync_pulse = 1'b0;
    sram_gnt = 1'b1;

    // reset state
    run(3);
    check("rst_req",   36'(sram_req), 36'(0));
    check("rst_we",    36'(sram_we), 36'(0));
    check("rst_addr",  36'(sram_addr), 36'(0));
    check("rst_cf",    36'(current_frame), 36'(0));
    check("rst_ovf",   36'(overflow), 36'(0));
    check("rst_state", 36'(dbg_state), 36'(IDLE));
    reset_n = 1'b1;
    run(2);

    // T1: single push, latency and address
    push(10'd5, 10'd3, 16'hABCD);
    check("t1_req_n1", 36'(sram_req), 36'(1));
    check("t1_we_n1",  36'(sram_we), 36'(0));
    tick();
    check("t1_we_n2",   36'(sram_we), 36'(1));
    check("t1_addr",    36'(sram_addr), 36'h80C05);
    check("t1_wdata",   36'(sram_wdata), 36'hABCD);
    tick();
    check("t1_we_n3",   36'(sram_we), 36'(1));
    check("t1_addr_n3", 36'(sram_addr), 36'h80C05);
    tick();
    check("t1_we_n4",  36'(sram_we), 36'(0));
    check("t1_req_n4", 36'(sram_req), 36'(0));
    exp_q.push_back({20'h80C05, 16'hABCD});
    compare_sb("t1");

    // T2: grant held off, 17 pushes into a 16-deep queue
    sram_gnt = 1'b0;
    for (int i = 0; i < 17; i++) push(10'(i), 10'd1, 16'(16'h1000 + i));
    check("t2_ovf", 36'(overflow), 36'(1));
    check("t2_req", 36'(sram_req), 36'(1));
    run(3);
    check("t2_no_we", 36'(got_q.size()), 36'(0));
    for (int i = 0; i < 16; i++) exp_q.push_back({20'(20'h80400 + i), 16'(16'h1000 + i)});
    sram_gnt = 1'b1;
    run(80);
    compare_sb("t2");
    check("t2_ovf_kept", 36'(overflow), 36'(1));

    // T3: flip requested with 3 words queued
    for (int i = 0; i < 3; i++) begin
      push(10'(10 + i), 10'd2, 16'(16'h3000 + i));
      exp_q.push_back({20'(20'h8080A + i), 16'(16'h3000 + i)});
    end
    engine_done = 1'b1;
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    flip_seen = 0;
    writes_at_flip = -1;
    cf_at_flip = 1'b0;
    ovf_at_flip = 1'b1;
    fd_after = 1'b1;
    for (int c = 0; c < 60 && flip_seen == 0; c++) begin
      tick();
      if (flip_done) begin
        flip_seen = 1;
        writes_at_flip = got_q.size();
        cf_at_flip = current_frame;
        ovf_at_flip = overflow;
        tick();
        fd_after = flip_done;
      end
    end
    engine_done = 1'b0;
    check("t3_flip_seen",   36'(flip_seen), 36'(1));
    check("t3_flip_writes", 36'(writes_at_flip), 36'(3));
    check("t3_cf",          36'(cf_at_flip), 36'(1));
    check("t3_ovf_clr",     36'(ovf_at_flip), 36'(0));
    check("t3_fd_pulse",    36'(fd_after), 36'(0));
    compare_sb("t3");
    push(10'd7, 10'd4, 16'h5A5A);
    exp_q.push_back({20'h01007, 16'h5A5A});
    run(6);
    compare_sb("t3_post");

    // T4: out-of-range coordinates dropped, edge coordinates accepted
    push(10'd640, 10'd0, 16'h1111);
    push(10'd0, 10'd480, 16'h2222);
    run(5);
    check("t4_req", 36'(sram_req), 36'(0));
    check("t4_ovf", 36'(overflow), 36'(0));
    compare_sb("t4_drop");
    push(10'd639, 10'd479, 16'h3333);
    exp_q.push_back({20'h77E7F, 16'h3333});
    run(6);
    compare_sb("t4_edge");

    // T5: reset in the middle of a write with 4 words still queued
    for (int i = 0; i < 5; i++) push(10'(i), 10'd9, 16'(16'h7000 + i));
    tick();
    check("t5_we_before", 36'(sram_we), 36'(1));
    reset_n = 1'b0;
    #1;
    check("t5_req",  36'(sram_req), 36'(0));
    check("t5_we",   36'(sram_we), 36'(0));
    check("t5_addr", 36'(sram_addr), 36'(0));
    check("t5_data", 36'(sram_wdata), 36'(0));
    check("t5_cf",   36'(current_frame), 36'(0));
    got_q.delete();
    run(2);
    reset_n = 1'b1;
    run(10);
    check("t5_req_after", 36'(sram_req), 36'(0));
    compare_sb("t5_after");

    // T6: zero data word
    push(10'd1, 10'd1, 16'h0000);
`ifndef FB_TRANSPARENT_SKIP_EN
    exp_q.push_back({20'h80401, 16'h0000});
`endif
    run(8);
    compare_sb("t6");
    check("t6_ovf", 36'(overflow), 36'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
